even_operand_stage: RTL and testbench

Register-fetch / operand-forwarding stage that sits directly upstream of the even execution pipe. It latches one decoded even-pipe instruction per cycle and resolves its three 128-bit source operands from the register file, the seven in-flight packed result stages, or the write-back bus. It stalls decode on read-after-write hazards whose producer result is not yet available. Its registered output bundle is the even pipe's instruction/operand input.

---
 rtl/even_operand_stage_pkg.sv | 41 ++++
 rtl/even_operand_stage_resolve.sv | 57 +++++
 rtl/even_operand_stage.sv | 157 +++++++++++++++
 tb/tb_even_operand_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/even_operand_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | even_operand_stage_pkg : packed-result layout and output bundle type     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package even_operand_stage_pkg;

  localparam int c_PR_W       = 143;
  localparam int c_DATA_W     = 128;
  localparam int c_ADDR_W     = 7;
  localparam int c_LAT_W      = 4;
  localparam int c_UNIT_W     = 3;

  localparam int c_UNIT_LSB   = 0;
  localparam int c_RESULT_LSB = 3;
  localparam int c_DST_LSB    = 131;
  localparam int c_LAT_LSB    = 138;
  localparam int c_REGWR_BIT  = 142;

  typedef logic [c_PR_W-1:0] packed_result_t;

  typedef struct packed {
    logic [31:0]         full_instr;
    logic [6:0]          instr_id;
    logic [2:0]          unit_id;
    logic [3:0]          latency;
    logic [6:0]          reg_dst;
    logic                reg_wr;
    logic [7:0]          imme7;
    logic [9:0]          imme10;
    logic [15:0]         imme16;
    logic [17:0]         imme18;
    logic [c_DATA_W-1:0] ra_data;
    logic [c_DATA_W-1:0] rb_data;
    logic [c_DATA_W-1:0] rc_data;
  } ex_bundle_t;

  localparam ex_bundle_t c_EX_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/even_operand_stage_resolve.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | operand_resolve : youngest-first forwarding search for one source        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module operand_resolve
  import even_operand_stage_pkg::*;
#(
  parameter int NUM_STAGES = 7
) (
  input  logic [c_ADDR_W-1:0]                    i_addr,
  input  logic                                   i_used,
  input  logic [c_DATA_W-1:0]                    i_rf_data,
  input  logic                                   i_s0_reg_wr,
  input  logic [c_ADDR_W-1:0]                    i_s0_dst,
  input  packed_result_t [NUM_STAGES-1:0]        i_stages,
  input  logic [c_ADDR_W-1:0]                    i_wb_addr,
  input  logic [c_DATA_W-1:0]                    i_wb_data,
  input  logic                                   i_wb_en,
  output logic [c_DATA_W-1:0]                    o_data,
  output logic                                   o_not_ready
);

  logic                w_found;
  logic                w_pending;
  logic [c_DATA_W-1:0] w_fwd;

  // The first match decides; older copies behind it are ignored entirely.
  always_comb begin
    w_found   = 1'b0;
    w_pending = 1'b0;
    w_fwd     = i_rf_data;
    if (i_s0_reg_wr && (i_s0_dst == i_addr)) begin
      w_found   = 1'b1;
      w_pending = 1'b1;
    end
    for (int k = 1; k <= NUM_STAGES; k++) begin
      if (!w_found && i_stages[k-1][c_REGWR_BIT] &&
          (i_stages[k-1][c_DST_LSB +: c_ADDR_W] == i_addr)) begin
        w_found = 1'b1;
        if (c_LAT_W'(k) >= i_stages[k-1][c_LAT_LSB +: c_LAT_W]) begin
          w_fwd = i_stages[k-1][c_RESULT_LSB +: c_DATA_W];
        end else begin
          w_pending = 1'b1;
        end
      end
    end
    if (!w_found && i_wb_en && (i_wb_addr == i_addr)) begin
      w_fwd = i_wb_data;
    end
  end

  assign o_data      = i_used ? w_fwd : i_rf_data;
  assign o_not_ready = i_used & w_pending;

endmodule
`default_nettype wire

// File: rtl/even_operand_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | even_operand_stage : operand fetch/forward and hazard stall, even pipe   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module even_operand_stage
  import even_operand_stage_pkg::*;
#(
  parameter int NUM_STAGES = 7,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [31:0]          in_full_instr,
  input  logic [6:0]           in_instr_id,
  input  logic [2:0]           in_unit_id,
  input  logic [3:0]           in_latency,
  input  logic [6:0]           in_reg_dst,
  input  logic                 in_reg_wr,
  input  logic [7:0]           in_imme7,
  input  logic [9:0]           in_imme10,
  input  logic [15:0]          in_imme16,
  input  logic [17:0]          in_imme18,
  input  logic [6:0]           in_ra_addr,
  input  logic [6:0]           in_rb_addr,
  input  logic [6:0]           in_rc_addr,
  input  logic                 in_ra_used,
  input  logic                 in_rb_used,
  input  logic                 in_rc_used,
  input  logic [127:0]         rf_ra_data,
  input  logic [127:0]         rf_rb_data,
  input  logic [127:0]         rf_rc_data,
  input  logic [142:0]         packed_result_1stage,
  input  logic [142:0]         packed_result_2stage,
  input  logic [142:0]         packed_result_3stage,
  input  logic [142:0]         packed_result_4stage,
  input  logic [142:0]         packed_result_5stage,
  input  logic [142:0]         packed_result_6stage,
  input  logic [142:0]         packed_result_7stage,
  input  logic [6:0]           wb_addr,
  input  logic [127:0]         wb_data,
  input  logic                 wb_en,
  output logic                 stall,
  output logic [31:0]          ex_full_instr,
  output logic [6:0]           ex_instr_id,
  output logic [2:0]           ex_unit_id,
  output logic [3:0]           ex_latency,
  output logic [6:0]           ex_reg_dst,
  output logic                 ex_reg_wr,
  output logic [7:0]           ex_imme7,
  output logic [9:0]           ex_imme10,
  output logic [15:0]          ex_imme16,
  output logic [17:0]          ex_imme18,
  output logic [127:0]         ex_ra_data,
  output logic [127:0]         ex_rb_data,
  output logic [127:0]         ex_rc_data,
  output logic [CNT_W-1:0]     stall_count
);

  ex_bundle_t                  r_ex;
  logic [CNT_W-1:0]            r_stall_count;
  ex_bundle_t                  w_next;
  logic                        w_stall;
  packed_result_t [6:0]        w_ports;
  packed_result_t [NUM_STAGES-1:0] w_stages;

  logic [2:0][c_ADDR_W-1:0]    w_addr;
  logic [2:0]                  w_used;
  logic [2:0][c_DATA_W-1:0]    w_rf;
  logic [2:0][c_DATA_W-1:0]    w_data;
  logic [2:0]                  w_not_ready;

  assign w_ports  = {packed_result_7stage, packed_result_6stage, packed_result_5stage,
                     packed_result_4stage, packed_result_3stage, packed_result_2stage,
                     packed_result_1stage};
  assign w_stages = w_ports[NUM_STAGES-1:0];

  assign w_addr = {in_rc_addr, in_rb_addr, in_ra_addr};
  assign w_used = {in_rc_used, in_rb_used, in_ra_used};
  assign w_rf   = {rf_rc_data, rf_rb_data, rf_ra_data};

  generate
    for (genvar g = 0; g < 3; g++) begin : g_src
      operand_resolve #(
        .NUM_STAGES (NUM_STAGES)
      ) u_resolve (
        .i_addr      (w_addr[g]),
        .i_used      (w_used[g]),
        .i_rf_data   (w_rf[g]),
        .i_s0_reg_wr (r_ex.reg_wr),
        .i_s0_dst    (r_ex.reg_dst),
        .i_stages    (w_stages),
        .i_wb_addr   (wb_addr),
        .i_wb_data   (wb_data),
        .i_wb_en     (wb_en),
        .o_data      (w_data[g]),
        .o_not_ready (w_not_ready[g])
      );
    end
  endgenerate

  // Reset and flush both mask the hazard so decode is never held by them.
  assign w_stall = rst & in_valid & ~flush & (|w_not_ready);
  assign stall   = w_stall;

  always_comb begin
    w_next            = c_EX_BUBBLE;
    w_next.full_instr = in_full_instr;
    w_next.instr_id   = in_instr_id;
    w_next.unit_id    = in_unit_id;
    w_next.latency    = in_latency;
    w_next.reg_dst    = in_reg_dst;
    w_next.reg_wr     = in_reg_wr;
    w_next.imme7      = in_imme7;
    w_next.imme10     = in_imme10;
    w_next.imme16     = in_imme16;
    w_next.imme18     = in_imme18;
    w_next.ra_data    = w_data[0];
    w_next.rb_data    = w_data[1];
    w_next.rc_data    = w_data[2];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ex          <= c_EX_BUBBLE;
      r_stall_count <= '0;
    end else begin
      if (!flush && in_valid && !w_stall) begin
        r_ex <= w_next;
      end else begin
        r_ex <= c_EX_BUBBLE;
      end
      if (w_stall) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign ex_full_instr = r_ex.full_instr;
  assign ex_instr_id   = r_ex.instr_id;
  assign ex_unit_id    = r_ex.unit_id;
  assign ex_latency    = r_ex.latency;
  assign ex_reg_dst    = r_ex.reg_dst;
  assign ex_reg_wr     = r_ex.reg_wr;
  assign ex_imme7      = r_ex.imme7;
  assign ex_imme10     = r_ex.imme10;
  assign ex_imme16     = r_ex.imme16;
  assign ex_imme18     = r_ex.imme18;
  assign ex_ra_data    = r_ex.ra_data;
  assign ex_rb_data    = r_ex.rb_data;
  assign ex_rc_data    = r_ex.rc_data;
  assign stall_count   = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_even_operand_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_even_operand_stage : directed vectors plus hazard/flush/reset runs    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_even_operand_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, flush, in_valid;
  logic [31:0]  in_full_instr;
  logic [6:0]   in_instr_id;
  logic [2:0]   in_unit_id;
  logic [3:0]   in_latency;
  logic [6:0]   in_reg_dst;
  logic         in_reg_wr;
  logic [7:0]   in_imme7;
  logic [9:0]   in_imme10;
  logic [15:0]  in_imme16;
  logic [17:0]  in_imme18;
  logic [6:0]   in_ra_addr, in_rb_addr, in_rc_addr;
  logic         in_ra_used, in_rb_used, in_rc_used;
  logic [127:0] rf_ra_data, rf_rb_data, rf_rc_data;
  logic [6:0]   wb_addr;
  logic [127:0] wb_data;
  logic         wb_en;
  logic         stall;
  logic [31:0]  ex_full_instr;
  logic [6:0]   ex_instr_id;
  logic [2:0]   ex_unit_id;
  logic [3:0]   ex_latency;
  logic [6:0]   ex_reg_dst;
  logic         ex_reg_wr;
  logic [7:0]   ex_imme7;
  logic [9:0]   ex_imme10;
  logic [15:0]  ex_imme16;
  logic [17:0]  ex_imme18;
  logic [127:0] ex_ra_data, ex_rb_data, ex_rc_data;
  logic [31:0]  stall_count;

  logic         pipe_mode;
  logic [142:0] tbl_stg  [1:7];
  logic [142:0] pipe_stg [1:7];
  logic [142:0] stg      [1:7];

  // Stand-in for the even pipe: shifts ex_* down, result = zero-extended instr word.
  always @(posedge clk) begin
    pipe_stg[1] <= {ex_reg_wr, ex_latency, ex_reg_dst, {96'h0, ex_full_instr}, ex_unit_id};
    for (int k = 2; k <= 7; k++) pipe_stg[k] <= pipe_stg[k-1];
  end

  always_comb begin
    for (int k = 1; k <= 7; k++) stg[k] = pipe_mode ? pipe_stg[k] : tbl_stg[k];
  end

  even_operand_stage #(.NUM_STAGES(7), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_full_instr(in_full_instr), .in_instr_id(in_instr_id), .in_unit_id(in_unit_id),
    .in_latency(in_latency), .in_reg_dst(in_reg_dst), .in_reg_wr(in_reg_wr),
    .in_imme7(in_imme7), .in_imme10(in_imme10), .in_imme16(in_imme16), .in_imme18(in_imme18),
    .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr), .in_rc_addr(in_rc_addr),
    .in_ra_used(in_ra_used), .in_rb_used(in_rb_used), .in_rc_used(in_rc_used),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data), .rf_rc_data(rf_rc_data),
    .packed_result_1stage(stg[1]), .packed_result_2stage(stg[2]),
    .packed_result_3stage(stg[3]), .packed_result_4stage(stg[4]),
    .packed_result_5stage(stg[5]), .packed_result_6stage(stg[6]),
    .packed_result_7stage(stg[7]),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_en(wb_en),
    .stall(stall),
    .ex_full_instr(ex_full_instr), .ex_instr_id(ex_instr_id), .ex_unit_id(ex_unit_id),
    .ex_latency(ex_latency), .ex_reg_dst(ex_reg_dst), .ex_reg_wr(ex_reg_wr),
    .ex_imme7(ex_imme7), .ex_imme10(ex_imme10), .ex_imme16(ex_imme16), .ex_imme18(ex_imme18),
    .ex_ra_data(ex_ra_data), .ex_rb_data(ex_rb_data), .ex_rc_data(ex_rc_data),
    .stall_count(stall_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [142:0] pr(input logic w, input logic [3:0] l,
                                      input logic [6:0] d, input logic [127:0] r);
    return {w, l, d, r, 3'd0};
  endfunction

  localparam logic [127:0] RA = {16{8'hAA}};
  localparam logic [127:0] RB = {16{8'hBB}};
  localparam logic [127:0] RC = {16{8'hCC}};

  typedef struct {
    logic [6:0]   ra, rb, rc;
    logic [2:0]   used;          // {ra, rb, rc}
    int           sa;            // stage index for pa, 0 = none
    logic [142:0] pa;
    int           sb;
    logic [142:0] pb;
    logic         wbe;
    logic [6:0]   wba;
    logic [127:0] wbd;
    logic         es;
    logic [127:0] ea, eb, ec;
  } vec_t;

  function automatic vec_t nv(input logic [6:0] ra, input logic [6:0] rb,
                              input logic [6:0] rc, input logic [2:0] used);
    vec_t v;
    v.ra = ra; v.rb = rb; v.rc = rc; v.used = used;
    v.sa = 0; v.pa = '0; v.sb = 0; v.pb = '0;
    v.wbe = 1'b0; v.wba = '0; v.wbd = '0;
    v.es = 1'b0; v.ea = RA; v.eb = RB; v.ec = RC;
    return v;
  endfunction

  task automatic drive_instr(input logic [31:0] fi, input logic wr, input logic [6:0] dst,
                             input logic [3:0] lat, input logic [6:0] ra, input logic ra_u);
    in_valid = 1'b1; in_full_instr = fi; in_reg_wr = wr; in_reg_dst = dst; in_latency = lat;
    in_ra_addr = ra; in_ra_used = ra_u; in_rb_used = 1'b0; in_rc_used = 1'b0;
  endtask

  vec_t vt [11];
  int   exp_cnt;
  int   n;

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; pipe_mode = 1'b1;
    in_full_instr = '0; in_instr_id = 7'h15; in_unit_id = 3'd2; in_latency = '0;
    in_reg_dst = '0; in_reg_wr = 1'b0; in_imme7 = 8'h7E; in_imme10 = 10'h3A5;
    in_imme16 = 16'hBEEF; in_imme18 = 18'h2ACE5;
    in_ra_addr = '0; in_rb_addr = '0; in_rc_addr = '0;
    in_ra_used = 1'b0; in_rb_used = 1'b0; in_rc_used = 1'b0;
    rf_ra_data = RA; rf_rb_data = RB; rf_rc_data = RC;
    wb_addr = '0; wb_data = '0; wb_en = 1'b0;
    for (int k = 1; k <= 7; k++) tbl_stg[k] = '0;

    vt[0] = nv(5, 6, 7, 3'b110);
    vt[1] = nv(5, 6, 7, 3'b111); vt[1].sa = 3; vt[1].pa = pr(1, 2, 5, 128'h1234); vt[1].ea = 128'h1234;
    vt[2] = nv(7, 1, 2, 3'b100); vt[2].sa = 2; vt[2].pa = pr(1, 6, 7, 128'h77);
    vt[2].sb = 5; vt[2].pb = pr(1, 2, 7, 128'h75); vt[2].es = 1'b1;
    vt[3] = nv(1, 2, 12, 3'b001); vt[3].wbe = 1'b1; vt[3].wba = 12; vt[3].wbd = 128'h55;
    vt[3].ec = 128'h55;
    vt[4] = nv(1, 3, 2, 3'b101); vt[4].sa = 1; vt[4].pa = pr(1, 5, 3, 128'h33);
    vt[5] = nv(1, 2, 9, 3'b001); vt[5].sa = 4; vt[5].pa = pr(1, 4, 9, 128'h99); vt[5].ec = 128'h99;
    vt[6] = nv(1, 2, 9, 3'b011); vt[6].sa = 4; vt[6].pa = pr(1, 5, 9, 128'h99); vt[6].es = 1'b1;
    vt[7] = nv(20, 2, 3, 3'b100); vt[7].sa = 7; vt[7].pa = pr(1, 7, 20, 128'h2020);
    vt[7].wbe = 1'b1; vt[7].wba = 20; vt[7].wbd = 128'hBAD; vt[7].ea = 128'h2020;
    vt[8] = nv(4, 2, 3, 3'b100); vt[8].sa = 1; vt[8].pa = pr(0, 1, 4, 128'h44);
    vt[9] = nv(0, 2, 3, 3'b100); vt[9].sa = 1; vt[9].pa = pr(1, 1, 0, 128'h100); vt[9].ea = 128'h100;
    vt[10] = nv(1, 8, 3, 3'b010); vt[10].sa = 1; vt[10].pa = pr(1, 1, 8, 128'h81);
    vt[10].sb = 6; vt[10].pb = pr(1, 2, 8, 128'h86); vt[10].eb = 128'h81;

    // Reset long enough to fill the stand-in pipe with bubbles.
    repeat (8) @(posedge clk);
    #1;
    chk("reset_ex_full", {96'h0, ex_full_instr}, 128'h0);
    chk("reset_ex_reg_wr", {127'h0, ex_reg_wr}, 128'h0);
    chk("reset_ex_ra", ex_ra_data, 128'h0);
    chk("reset_stall_count", {96'h0, stall_count}, 128'h0);
    chk("reset_stall", {127'h0, stall}, 128'h0);

    // Latency-4 producer into r9, consumer of r9 right behind it.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); drive_instr(32'hDEAD0001, 1'b1, 7'd9, 4'd4, 7'd0, 1'b0);
    @(negedge clk);
    chk("prod_ex_full", {96'h0, ex_full_instr}, 128'hDEAD0001);
    chk("prod_ex_lat", {124'h0, ex_latency}, 128'h4);
    chk("prod_ex_imme16", {112'h0, ex_imme16}, 128'hBEEF);
    drive_instr(32'hC0000002, 1'b0, 7'd0, 4'd0, 7'd9, 1'b1);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!stall) break;
      n++;
      @(negedge clk);
    end
    chk("haz_stall_cycles", 128'(n), 128'd4);
    @(posedge clk); #1;
    chk("haz_ex_full", {96'h0, ex_full_instr}, 128'hC0000002);
    chk("haz_ex_ra_fwd", ex_ra_data, 128'hDEAD0001);
    chk("haz_stall_count", {96'h0, stall_count}, 128'd4);
    exp_cnt = 4;

    // Table vectors, applied back to back against driven stage contents.
    pipe_mode = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      for (int k = 1; k <= 7; k++) tbl_stg[k] = '0;
      if (vt[i].sa != 0) tbl_stg[vt[i].sa] = vt[i].pa;
      if (vt[i].sb != 0) tbl_stg[vt[i].sb] = vt[i].pb;
      in_valid = 1'b1; in_full_instr = 32'h1000 + 32'(i); in_reg_wr = 1'b0;
      in_reg_dst = '0; in_latency = '0;
      in_ra_addr = vt[i].ra; in_rb_addr = vt[i].rb; in_rc_addr = vt[i].rc;
      {in_ra_used, in_rb_used, in_rc_used} = vt[i].used;
      wb_en = vt[i].wbe; wb_addr = vt[i].wba; wb_data = vt[i].wbd;
      #1;
      chk($sformatf("v%0d_stall", i), {127'h0, stall}, {127'h0, vt[i].es});
      exp_cnt += vt[i].es ? 1 : 0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_ex_full", i), {96'h0, ex_full_instr},
          vt[i].es ? 128'h0 : 128'(32'h1000 + 32'(i)));
      chk($sformatf("v%0d_ex_ra", i), ex_ra_data, vt[i].es ? 128'h0 : vt[i].ea);
      chk($sformatf("v%0d_ex_rb", i), ex_rb_data, vt[i].es ? 128'h0 : vt[i].eb);
      chk($sformatf("v%0d_ex_rc", i), ex_rc_data, vt[i].es ? 128'h0 : vt[i].ec);
    end
    chk("tbl_stall_count", {96'h0, stall_count}, 128'(exp_cnt));

    // Flush while stalled, then reset mid-stream.
    @(negedge clk);
    pipe_mode = 1'b1; wb_en = 1'b0;
    for (int k = 1; k <= 7; k++) tbl_stg[k] = '0;
    drive_instr(32'hAAA1, 1'b1, 7'd11, 4'd3, 7'd0, 1'b0);
    @(negedge clk);
    drive_instr(32'hBBB2, 1'b0, 7'd0, 4'd0, 7'd11, 1'b1);
    #1;
    chk("fl_stall_before", {127'h0, stall}, 128'h1);
    exp_cnt += 1;
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fl_stall_masked", {127'h0, stall}, 128'h0);
    @(posedge clk); #1;
    chk("fl_ex_full", {96'h0, ex_full_instr}, 128'h0);
    chk("fl_ex_reg_wr", {127'h0, ex_reg_wr}, 128'h0);
    chk("fl_ex_ra", ex_ra_data, 128'h0);
    chk("fl_stall_count", {96'h0, stall_count}, 128'(exp_cnt));
    @(negedge clk);
    flush = 1'b0;
    drive_instr(32'hCCC3, 1'b1, 7'd30, 4'd1, 7'd0, 1'b0);
    @(posedge clk); #1;
    chk("post_fl_ex_full", {96'h0, ex_full_instr}, 128'hCCC3);
    @(negedge clk);
    drive_instr(32'hDDD4, 1'b0, 7'd0, 4'd0, 7'd30, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_stall_forced", {127'h0, stall}, 128'h0);
    @(posedge clk); #1;
    chk("rst_ex_full", {96'h0, ex_full_instr}, 128'h0);
    chk("rst_ex_reg_wr", {127'h0, ex_reg_wr}, 128'h0);
    chk("rst_ex_imme18", {110'h0, ex_imme18}, 128'h0);
    chk("rst_stall_count", {96'h0, stall_count}, 128'h0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
